// File: rtl/branch_predict_if.sv
// Fetch/execute bus between the CPU pipeline and the branch predictor.
//   fetch_pc       : PC being fetched (CPU -> predictor)
//   pred_taken     : prediction for fetch_pc (predictor -> CPU)
//   ex_valid       : instruction present in execute
//   ex_pc          : PC of the execute instruction
//   BrOp           : branch op of the execute instruction
//   ex_pred_taken  : prediction carried with the execute instruction
//   neg, zero      : ALU flags of the execute instruction
//   muxc5          : PC source select (predictor -> CPU)
//   flush          : kill younger instructions (predictor -> CPU)
interface branch_predict_if #(
    parameter int PC_W = 16
);
    logic [PC_W-1:0] fetch_pc;
    logic            pred_taken;
    logic            ex_valid;
    logic [PC_W-1:0] ex_pc;
    logic [2:0]      BrOp;
    logic            ex_pred_taken;
    logic            neg;
    logic            zero;
    logic [1:0]      muxc5;
    logic            flush;

    modport master (
        output fetch_pc, ex_valid, ex_pc, BrOp, ex_pred_taken, neg, zero,
        input  pred_taken, muxc5, flush
    );

    modport slave (
        input  fetch_pc, ex_valid, ex_pc, BrOp, ex_pred_taken, neg, zero,
        output pred_taken, muxc5, flush
    );
endinterface

// File: rtl/branch_predict_control.sv
// Branch resolve and 2-bit saturating-counter prediction.
// Resolves branch/jump ops in execute, drives the PC-source select muxc5,
// flags mispredictions with flush, trains a direct-mapped counter table and
// keeps saturating branch / mispredict statistics.
//   clk, rst_n     : clock, synchronous active-low reset
//   bus            : fetch/execute bus (slave side)
//   ready          : table initialisation finished
//   br_count       : resolved conditional branches
//   mispred_count  : mispredicted conditional branches
//
// state | meaning
// INIT  | writing 2'b01 to table entry init_idx, one entry per cycle
// RUN   | predicting, resolving and training
module branch_predict_control #(
    parameter int PC_W  = 16,
    parameter int IDX_W = 4,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    branch_predict_if.slave  bus,
    output logic             ready,
    output logic [CNT_W-1:0] br_count,
    output logic [CNT_W-1:0] mispred_count
);
    localparam int DEPTH = 2 ** IDX_W;

    typedef enum logic {INIT, RUN} state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] init_idx;
    logic [1:0]       ctr_tbl [DEPTH];

    logic [IDX_W-1:0] fetch_idx, ex_idx;
    logic             is_cond, actual, train, mispred;
    logic [1:0]       ctr_old, ctr_new;

    // Upper PC bits only matter for aliasing, which is intentional.
    logic unused_pc_bits;
    assign unused_pc_bits = ^{bus.fetch_pc[PC_W-1:IDX_W], bus.ex_pc[PC_W-1:IDX_W]};

    assign fetch_idx = bus.fetch_pc[IDX_W-1:0];
    assign ex_idx    = bus.ex_pc[IDX_W-1:0];
    assign ready     = (state_q == RUN);

    always_comb begin
        state_d        = state_q;
        is_cond        = 1'b0;
        actual         = 1'b0;
        train          = 1'b0;
        mispred        = 1'b0;
        bus.muxc5      = 2'd0;
        bus.flush      = 1'b0;
        bus.pred_taken = 1'b0;
        ctr_old        = ctr_tbl[ex_idx];
        ctr_new        = ctr_old;

        case (state_q)
            INIT: begin
                if (init_idx == IDX_W'(DEPTH - 1))
                    state_d = RUN;
            end
            RUN: begin
                bus.pred_taken = ctr_tbl[fetch_idx][1];
                if (bus.ex_valid) begin
                    case (bus.BrOp)
                        3'b001: begin bus.muxc5 = 2'd1; bus.flush = 1'b1; end
                        3'b110: begin bus.muxc5 = 2'd2; bus.flush = 1'b1; end
                        3'b010: begin is_cond = 1'b1; actual = bus.zero;  end
                        3'b011: begin is_cond = 1'b1; actual = !bus.zero; end
                        3'b100: begin is_cond = 1'b1; actual = bus.neg;   end
                        3'b101: begin is_cond = 1'b1; actual = !bus.neg;  end
                        default: ;
                    endcase
                    if (is_cond) begin
                        train = 1'b1;
                        if (actual != bus.ex_pred_taken) begin
                            mispred   = 1'b1;
                            bus.flush = 1'b1;
                            bus.muxc5 = actual ? 2'd1 : 2'd3;
                        end
                        if (actual && ctr_old != 2'd3)
                            ctr_new = ctr_old + 2'd1;
                        else if (!actual && ctr_old != 2'd0)
                            ctr_new = ctr_old - 2'd1;
                    end
                end
            end
            default: state_d = INIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= INIT;
            init_idx      <= '0;
            br_count      <= '0;
            mispred_count <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == INIT)
                init_idx <= init_idx + IDX_W'(1);
            if (train && br_count != '1)
                br_count <= br_count + CNT_W'(1);
            if (mispred && mispred_count != '1)
                mispred_count <= mispred_count + CNT_W'(1);
        end
    end

    // Table has no reset of its own; INIT rewrites every entry.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            if (state_q == INIT)
                ctr_tbl[init_idx] <= 2'b01;
            else if (train)
                ctr_tbl[ex_idx] <= ctr_new;
        end
    end
endmodule

// File: tb/tb_branch_predict_control.sv
module tb_branch_predict_control;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        ready;
    logic [15:0] br_count, mispred_count;
    int          errors = 0;
    int          checks = 0;

    branch_predict_if #(.PC_W(16)) bus ();

    branch_predict_control #(.PC_W(16), .IDX_W(4), .CNT_W(16)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .bus           (bus),
        .ready         (ready),
        .br_count      (br_count),
        .mispred_count (mispred_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ex(input logic v, input logic [2:0] op, input logic [15:0] pc,
                      input logic pt, input logic n, input logic z);
        bus.ex_valid      = v;
        bus.BrOp          = op;
        bus.ex_pc         = pc;
        bus.ex_pred_taken = pt;
        bus.neg           = n;
        bus.zero          = z;
        #1;
    endtask

    task automatic resolve(input string tag, input logic [1:0] mx, input logic fl);
        check({tag, "_muxc5"}, 32'(bus.muxc5), 32'(mx));
        check({tag, "_flush"}, 32'(bus.flush), 32'(fl));
    endtask

    task automatic stats(input string tag, input int br, input int mis);
        check({tag, "_br"},  32'(br_count), br);
        check({tag, "_mis"}, 32'(mispred_count), mis);
    endtask

    task automatic pred_at(input string tag, input logic [15:0] pc, input logic exp);
        bus.fetch_pc = pc;
        #1;
        check(tag, 32'(bus.pred_taken), 32'(exp));
    endtask

    task automatic all_not_taken(input string tag);
        for (int i = 0; i < 16; i++) pred_at(tag, 16'(i), 1'b0);
    endtask

    initial begin
        rst_n = 1'b0;
        bus.fetch_pc = '0;
        ex(1'b0, 3'b000, 16'h0, 1'b0, 1'b0, 1'b0);
        tick();
        tick();
        stats("reset", 0, 0);
        check("reset_ready", 32'(ready), 0);
        rst_n = 1'b1;

        // INIT: ready low for 16 edges; execute activity is ignored.
        for (int k = 0; k <= 16; k++) begin
            check("init_ready", 32'(ready), (k >= 16) ? 1 : 0);
            if (k < 16) begin
                check("init_pred", 32'(bus.pred_taken), 0);
                ex(1'b1, (k % 2 == 0) ? 3'b010 : 3'b001, 16'h5, 1'b0, 1'b0, 1'b1);
                resolve("init_ignored", 2'd0, 1'b0);
                tick();
            end
        end
        ex(1'b0, 3'b000, 16'h0, 1'b0, 1'b0, 1'b0);
        stats("init_nostats", 0, 0);
        all_not_taken("init_pred_all");

        // BEQ taken, predicted not-taken: counter 1 -> 2.
        ex(1'b1, 3'b010, 16'h0005, 1'b0, 1'b0, 1'b1);
        resolve("beq_mis", 2'd1, 1'b1);
        tick();
        ex(1'b0, 3'b000, 16'h0, 1'b0, 1'b0, 1'b0);
        pred_at("beq_pred", 16'h0005, 1'b1);
        stats("beq", 1, 1);

        // BNE taken x3 at aliased 0x15: 2 -> 3 -> 3 -> 3.
        for (int k = 0; k < 3; k++) begin
            ex(1'b1, 3'b011, 16'h0015, 1'b1, 1'b0, 1'b0);
            resolve("bne_hit", 2'd0, 1'b0);
            tick();
        end
        stats("bne_sat", 4, 1);
        ex(1'b1, 3'b011, 16'h0015, 1'b1, 1'b0, 1'b1);
        resolve("bne_nt", 2'd3, 1'b1);
        tick();
        ex(1'b0, 3'b000, 16'h0, 1'b0, 1'b0, 1'b0);
        pred_at("bne_pred_2", 16'h0005, 1'b1);
        stats("bne_nt", 5, 2);
        ex(1'b1, 3'b011, 16'h0015, 1'b1, 1'b0, 1'b1);
        resolve("bne_nt2", 2'd3, 1'b1);
        tick();
        ex(1'b0, 3'b000, 16'h0, 1'b0, 1'b0, 1'b0);
        pred_at("bne_pred_1", 16'h0005, 1'b0);
        stats("bne_nt2", 6, 3);

        // Unconditional ops and none/reserved never train or count.
        ex(1'b1, 3'b001, 16'h0005, 1'b0, 1'b0, 1'b0);
        resolve("j", 2'd1, 1'b1);
        tick();
        ex(1'b1, 3'b110, 16'h0005, 1'b0, 1'b0, 1'b0);
        resolve("jr", 2'd2, 1'b1);
        tick();
        ex(1'b1, 3'b111, 16'h0005, 1'b0, 1'b0, 1'b0);
        resolve("reserved", 2'd0, 1'b0);
        tick();
        ex(1'b1, 3'b000, 16'h0005, 1'b1, 1'b0, 1'b0);
        resolve("none", 2'd0, 1'b0);
        tick();
        ex(1'b0, 3'b010, 16'h0005, 1'b0, 1'b0, 1'b1);
        resolve("not_valid", 2'd0, 1'b0);
        tick();
        stats("jumps", 6, 3);
        pred_at("jumps_pred", 16'h0005, 1'b0);

        // BGE taken, predicted taken; same-cycle fetch sees old counter (1).
        bus.fetch_pc = 16'h0025;
        ex(1'b1, 3'b101, 16'h0005, 1'b1, 1'b0, 1'b0);
        resolve("bge", 2'd0, 1'b0);
        check("bge_old", 32'(bus.pred_taken), 0);
        tick();
        ex(1'b0, 3'b000, 16'h0, 1'b0, 1'b0, 1'b0);
        check("bge_new", 32'(bus.pred_taken), 1);
        stats("bge", 7, 3);

        // BLT taken, predicted not-taken at idx 9.
        ex(1'b1, 3'b100, 16'h0009, 1'b0, 1'b1, 1'b0);
        resolve("blt", 2'd1, 1'b1);
        tick();
        ex(1'b0, 3'b000, 16'h0, 1'b0, 1'b0, 1'b0);
        pred_at("blt_pred", 16'h0009, 1'b1);
        stats("blt", 8, 4);

        // Reset during training: pending update discarded, INIT rerun.
        ex(1'b1, 3'b010, 16'h0003, 1'b0, 1'b0, 1'b1);
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        ex(1'b0, 3'b000, 16'h0, 1'b0, 1'b0, 1'b0);
        check("rst2_ready", 32'(ready), 0);
        stats("rst2", 0, 0);
        for (int k = 0; k < 16; k++) tick();
        check("rst2_ready_up", 32'(ready), 1);
        all_not_taken("rst2_pred_all");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/branch_predict_control.md
# branch_predict_control

Parametrised successor to the combinational branch decision logic: it resolves branch/jump operations in execute and drives the PC-source select `muxc5`. It adds a direct-mapped table of 2-bit saturating counters, which supplies a taken/not-taken prediction to fetch and is trained at resolve time. It flags mispredictions for pipeline flush and keeps saturating branch and mispredict statistics. It sits between the fetch PC logic and the execute stage's ALU flags.

## Interface
- `PC_W`, default 16: width of PCs presented on both ports.
- `IDX_W`, default 4: table index bits; table depth is `2**IDX_W` entries.
- `CNT_W`, default 16: width of the statistics counters.
- `clk`  in  1: single clock; all state updates on rising edge.
- `rst_n`  in  1: reset, synchronous, active-low.
- `ready`  out  1: high once table initialisation is complete; CPU stalls fetch/execute while low.
- `fetch_pc`  in  PC_W: PC being fetched.
- `pred_taken`  out  1: prediction for `fetch_pc`, combinational from table state.
- `ex_valid`  in  1: an instruction is in execute this cycle.
- `ex_pc`  in  PC_W: PC of the execute instruction; used for index/update.
- `BrOp`  in  3: branch op of the execute instruction.
- `ex_pred_taken`  in  1: prediction carried down the pipe with the instruction.
- `neg`, `zero`  in  1 each: ALU flags for the execute instruction.
- `muxc5`  out  2: PC source. 0 = sequential/keep fetch path, 1 = branch/jump target, 2 = jump register, 3 = recovery to `ex_pc+1`.
- `flush`  out  1: kill younger instructions this cycle.
- `br_count`, `mispred_count`  out  CNT_W each: statistics.

## Operation
- FSM states are INIT and RUN.
  - Reset enters INIT with `init_idx` = 0.
  - INIT writes entry `init_idx` to 2'b01 (weakly not-taken) and increments `init_idx` each cycle.
  - After the write of entry `2**IDX_W-1`, the next state is RUN.
  - INIT lasts exactly `2**IDX_W` cycles.
- Index is `pc[IDX_W-1:0]`, giving aliasing by low PC bits. The prediction is `table[fetch_pc idx][1]`. `pred_taken` = 0 in INIT.
- BrOp decode (actual outcome):
  - 000: none.
  - 001: J.
  - 010: BEQ, taken iff `zero`.
  - 011: BNE, taken iff `!zero`.
  - 100: BLT, taken iff `neg`.
  - 101: BGE, taken iff `!neg`.
  - 110: JR.
  - 111: reserved, treated as none.
- Resolve outputs (combinational, RUN and `ex_valid`=1):
  - J: `muxc5`=1, `flush`=1.
  - JR: `muxc5`=2, `flush`=1.
  - Conditional, actual == `ex_pred_taken`: `muxc5`=0, `flush`=0.
  - Conditional, taken but predicted not-taken: `muxc5`=1, `flush`=1.
  - Conditional, not taken but predicted taken: `muxc5`=3, `flush`=1.
  - None/reserved, `ex_valid`=0, or INIT: `muxc5`=0, `flush`=0.
- Training applies only to conditional ops in RUN with `ex_valid`. The entry at `ex_pc` idx is incremented (saturating at 3) if taken, decremented (saturating at 0) if not taken. J/JR/none never modify the table.
- Statistics:
  - `br_count` increments on every resolved conditional.
  - `mispred_count` increments whenever a conditional raises `flush`.
  - Both saturate at all-ones and never wrap.

## Timing
- Reset (`rst_n`=0 at an edge): state=INIT, `init_idx`=0, `ready`=0, `br_count`=0, `mispred_count`=0. Table contents are rewritten by INIT; they are not cleared in one cycle.
- With no resolve activity, `pred_taken`=0 and `muxc5`=0, `flush`=0 from reset onward.
- `ready` rises on the first cycle in RUN: `2**IDX_W` edges after reset deasserts.
- `muxc5`/`flush` have zero latency: same cycle as `ex_valid`/`BrOp`/flags.
- Table update and statistics become visible at the next rising edge (1-cycle latency).
- Same-cycle fetch and update of the same index: `pred_taken` reflects the old counter. There is no bypass.
- `rst_n` low mid-operation: the next edge restarts INIT regardless of state, and any pending training in that cycle is discarded.
- `ex_valid` asserted during INIT is ignored: no outputs, no training, no statistics.

## Test plan
- Reset with IDX_W=4, then hold `rst_n`=1 -> `ready`=0 for 16 cycles and 1 from cycle 17; `pred_taken`=0 for every index.
- BEQ at `ex_pc`=0x0005, `zero`=1, `ex_pred_taken`=0 -> `muxc5`=1, `flush`=1 that cycle. Next cycle `fetch_pc`=0x0005 gives `pred_taken`=1 (counter 2), and `mispred_count`=1, `br_count`=1.
- BNE at `ex_pc`=0x0015 (aliases idx 5), taken three times -> counter saturates at 3. Then not taken once with `ex_pred_taken`=1 -> `muxc5`=3, `flush`=1, and `pred_taken` remains 1 (counter 2).
- J and JR with `ex_valid`=1 -> `muxc5`=1/2, `flush`=1; `br_count` unchanged and table unchanged.
- BGE with `neg`=0, `ex_pred_taken`=1 -> `muxc5`=0, `flush`=0. In the same cycle, `fetch_pc` at the same index reads the old value; the new value appears next cycle.
- Drive `rst_n`=0 for one edge during training -> `ready`=0, both statistics counters 0; all entries read not-taken after INIT.
